fetch_unit: RTL and testbench

Fetch stage of the pipelined core, directly upstream of the hazard unit's Decode-stage consumers. Holds the program counter, drives a req/ack instruction-memory port that tolerates variable latency, and owns the IF/ID pipeline register feeding Decode. It obeys the active-low `StallF`/`StallD` enables from the hazard unit and takes branch redirects from Decode.

---
 rtl/fetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: program counter, req/ack instruction-memory port with a one-entry
// skid buffer for variable latency, and the IF/ID pipeline register feeding Decode.
module fetch_unit #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               PCSrcD,
    input  logic [ADDR_W-1:0]  PCBranchD,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  PCF,
    output logic [INSTR_W-1:0] InstrD,
    output logic [ADDR_W-1:0]  PCPlus1D,
    output logic               ValidD
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t              state_q;
    logic                kill_q;
    logic [INSTR_W-1:0]  skid_q;
    logic [ADDR_W-1:0]   pcf_q;
    logic [INSTR_W-1:0]  instr_q;
    logic [ADDR_W-1:0]   pcp1_q;
    logic                valid_q;

    logic                redirect;
    logic [ADDR_W-1:0]   pcf_inc;

    // Redirect qualification and wrapping PC increment.
    always_comb begin
        redirect = PCSrcD && StallD;
        pcf_inc  = pcf_q + ADDR_W'(1);
    end

    // Fetch FSM, PC, skid buffer and IF/ID register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            kill_q  <= 1'b0;
            skid_q  <= '0;
            pcf_q   <= RESET_PC;
            instr_q <= '0;
            pcp1_q  <= '0;
            valid_q <= 1'b0;
        end else if (redirect) begin
            // A request still waiting for its ack must have that ack discarded;
            // an ack arriving right now is simply dropped.
            state_q <= S_FETCH;
            kill_q  <= (state_q == S_FETCH) && !imem_ack;
            pcf_q   <= PCBranchD;
            instr_q <= '0;
            pcp1_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            // Decode loads a bubble unless a real instruction is delivered below.
            if (StallD) begin
                instr_q <= '0;
                valid_q <= 1'b0;
            end
            if (state_q == S_FETCH) begin
                if (imem_ack && kill_q) begin
                    kill_q <= 1'b0;
                end else if (imem_ack && StallF && StallD) begin
                    instr_q <= imem_rdata;
                    pcp1_q  <= pcf_inc;
                    valid_q <= 1'b1;
                    pcf_q   <= pcf_inc;
                end else if (imem_ack) begin
                    skid_q  <= imem_rdata;
                    state_q <= S_HOLD;
                end
            end else begin
                if (StallF && StallD) begin
                    instr_q <= skid_q;
                    pcp1_q  <= pcf_inc;
                    valid_q <= 1'b1;
                    pcf_q   <= pcf_inc;
                    state_q <= S_FETCH;
                end
            end
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pcf_q;
    assign PCF       = pcf_q;
    assign InstrD    = instr_q;
    assign PCPlus1D  = pcp1_q;
    assign ValidD    = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: variable-latency memory model, directed scenarios
// and randomized traffic checked against a buffer-based reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        StallF;
    logic        StallD;
    logic        PCSrcD;
    logic [15:0] PCBranchD;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] PCF;
    logic [15:0] InstrD;
    logic [15:0] PCPlus1D;
    logic        ValidD;

    fetch_unit #(
        .ADDR_W   (16),
        .INSTR_W  (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .StallF     (StallF),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .PCF        (PCF),
        .InstrD     (InstrD),
        .PCPlus1D   (PCPlus1D),
        .ValidD     (ValidD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory model: latches address at request start ----------------
    logic        mem_busy;
    logic [15:0] mem_addr;
    int unsigned mem_cnt;
    logic        lat_rand;
    int unsigned lat_fix;

    task automatic mem_reset();
        mem_busy   = 1'b0;
        mem_addr   = '0;
        mem_cnt    = 0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic mem_drive();
        if (imem_ack) mem_busy = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'($urandom);
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_cnt  = lat_rand ? $urandom_range(0, 3) : lat_fix;
            end
            if (mem_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = 16'h1000 + mem_addr;
            end else begin
                mem_cnt--;
            end
        end
    endtask

    // ---------------- reference model ----------------
    // Returned instructions go into a buffer; Decode takes one when both enables allow.
    logic [15:0] m_pc, m_instr, m_pcp1;
    logic        m_valid, m_kill;
    logic [15:0] m_buf[$];

    task automatic model_reset();
        m_pc = 16'h0000; m_instr = '0; m_pcp1 = '0; m_valid = 1'b0; m_kill = 1'b0;
        m_buf.delete();
    endtask

    task automatic model_step(input logic f, input logic d, input logic s, input logic [15:0] t,
                              input logic ack, input logic [15:0] rdata);
        if (s && d) begin
            m_kill  = (m_buf.size() == 0) && !ack;
            m_buf.delete();
            m_pc    = t;
            m_instr = '0; m_pcp1 = '0; m_valid = 1'b0;
        end else begin
            if (m_buf.size() == 0 && ack) begin
                if (m_kill) m_kill = 1'b0;
                else        m_buf.push_back(rdata);
            end
            if (m_buf.size() > 0 && f && d) begin
                m_instr = m_buf.pop_front();
                m_pc    = m_pc + 16'd1;
                m_pcp1  = m_pc;
                m_valid = 1'b1;
            end else if (d) begin
                m_instr = '0;
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check_model();
        logic [15:0] want_instr;
        check_eq("PCF", PCF, m_pc);
        check_eq("InstrD", InstrD, m_instr);
        check_eq("PCPlus1D", PCPlus1D, m_pcp1);
        check_eq("ValidD", ValidD, m_valid);
        check_eq("imem_req", imem_req, m_buf.size() == 0);
        check_eq("imem_addr", imem_addr, m_pc);
        if (ValidD) begin
            want_instr = 16'h1000 + PCPlus1D - 16'd1;
            check_eq("instr_vs_pc", InstrD, want_instr);
        end
    endtask

    // One cycle: check state, drive inputs and memory at the negedge, advance model.
    task automatic step(input logic f, input logic d, input logic s, input logic [15:0] t);
        check_model();
        StallF    = f;
        StallD    = d;
        PCSrcD    = s;
        PCBranchD = t;
        mem_drive();
        model_step(f, d, s, t, imem_ack, imem_rdata);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = '0;
        lat_rand = 1'b0; lat_fix = 0;
        mem_reset();
        model_reset();
        #1;
        check_model();
        @(negedge clk);
        rst_n = 1'b1;

        // zero-wait stream, then stall at PCF=5
        for (int i = 0; i < 5; i++) step(1, 1, 0, 16'h0);
        check_eq("zw_pcf", PCF, 16'd5);
        check_eq("zw_instr", InstrD, 16'h1004);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0);
        check_eq("stall_pcf", PCF, 16'd5);
        check_eq("stall_instr", InstrD, 16'h1004);
        check_eq("stall_hold", imem_req, 1'b0);
        step(1, 1, 0, 16'h0);
        check_eq("release_instr", InstrD, 16'h1005);
        check_eq("release_pcf", PCF, 16'd6);

        // redirect while request to 7 is pending with 3-cycle latency
        lat_fix = 3;
        for (int i = 0; i < 40 && PCF != 16'd7; i++) step(1, 1, 0, 16'h0);
        check_eq("reach_pc7", PCF, 16'd7);
        step(1, 1, 0, 16'h0);
        step(1, 1, 1, 16'h0040);
        check_eq("redir_valid", ValidD, 1'b0);
        check_eq("redir_pcf", PCF, 16'h0040);
        for (int i = 0; i < 40 && !ValidD; i++) step(1, 1, 0, 16'h0);
        check_eq("redir_wait", ValidD, 1'b1);
        check_eq("redir_instr", InstrD, 16'h1040);

        // wrap-around
        lat_rand = 1'b1;
        step(1, 1, 1, 16'hFFFF);
        for (int i = 0; i < 40 && !ValidD; i++) step(1, 1, 0, 16'h0);
        check_eq("wrap_instr0", InstrD, 16'h0FFF);
        check_eq("wrap_pcp1_0", PCPlus1D, 16'h0000);
        step(1, 1, 0, 16'h0);
        for (int i = 0; i < 40 && !ValidD; i++) step(1, 1, 0, 16'h0);
        check_eq("wrap_instr1", InstrD, 16'h1000);
        check_eq("wrap_pcp1_1", PCPlus1D, 16'h0001);

        // redirect in the same cycle as an ack; ignored redirect under StallD=0
        lat_rand = 1'b0; lat_fix = 0;
        for (int i = 0; i < 6; i++) step(1, 1, 0, 16'h0);
        step(1, 1, 1, 16'h0020);
        check_eq("sim_pcf", PCF, 16'h0020);
        check_eq("sim_valid", ValidD, 1'b0);
        check_eq("sim_instr", InstrD, 16'h0000);
        check_eq("sim_pcp1", PCPlus1D, 16'h0000);
        step(1, 1, 0, 16'h0);
        check_eq("sim_next", InstrD, 16'h1020);
        step(1, 0, 1, 16'h0099);
        check_eq("ign_pcf", PCF, 16'h0021);
        check_eq("ign_instr", InstrD, 16'h1020);

        // randomized traffic
        lat_rand = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, 16'($urandom));
        end

        // asynchronous reset in the middle of HOLD
        lat_rand = 1'b0; lat_fix = 0;
        for (int i = 0; i < 4; i++) step(1, 1, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        check_eq("pre_reset_hold", imem_req, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        mem_reset();
        model_reset();
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("first_addr", imem_addr, 16'h0000);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 16'h0);
        check_eq("post_reset_instr", InstrD, 16'h1003);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
